l2req_arbiter_rr: RTL and testbench
===================================

// Module: l2req_arbiter_rr
// PURPOSE
//  N-input arbiter merging L1 icache, L1 dcache, store buffer and any future L1 units onto one core L2 request port.
//  Registered output stage; the next request is granted in the same cycle the L2 accepts the current one.
//  Round-robin or fixed-priority arbitration, with a starvation guard in fixed mode.
//  Sits between the per-core L1 units and the core's l2req_packet/l2req_ready boundary.
// PARAMETERS
//  NUM_REQ        3   number of requesters (2..8); index 0 = icache, 1 = dcache, 2 = store buffer
//  FIXED_PRIO     0   0 = round-robin; 1 = lowest index wins
//  STARVE_LIMIT  15   fixed mode only: consecutive lost-arbitration cycles before a requester is force-granted (1..255)
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    asynchronous, active-high
//  req_packet     in   l2req_packet_t[N]    per-requester request; .valid = request pending; held stable until req_ready[i]
//  req_ready      out  N                    one-cycle pulse: packet i latched this cycle
//  l2req_ready    in   1                    L2 accepts l2req_packet this cycle when its .valid = 1
//  l2req_packet   out  l2req_packet_t       registered request to L2
//  grant_id       out  $clog2(NUM_REQ)      index of the requester that owns l2req_packet
//  pc_event_l2req_stall out 1               1 while l2req_packet.valid && !l2req_ready
// BEHAVIOUR
//  Reset: l2req_packet = all-zero (.valid = 0); req_ready = 0; grant_id = 0; rr pointer = 0; starve counters = 0.
//  Output slot is free when !l2req_packet.valid or l2req_ready (drain and refill in the same cycle).
//  Grant, combinational:
//    - Made only when the slot is free and at least one req_packet[i].valid is set.
//    - On grant, req_ready[g] = 1, and the output register loads req_packet[g] and grant_id <= g at the next edge.
//  Latency: request valid at edge k with slot free -> l2req_packet.valid at edge k+1.
//    Back-to-back accepts give 1 request per cycle.
//  No grant: output register holds; if it drained, .valid <= 0 and the other fields hold.
//  Round-robin (FIXED_PRIO = 0):
//    - Search starts at ptr; ptr <= (g+1) mod NUM_REQ on each grant; ptr holds otherwise.
//    - Wraps from NUM_REQ-1 to 0.
//  Fixed (FIXED_PRIO = 1):
//    - Lowest valid index wins.
//    - Per-requester counter starve[i] increments, saturating at 255, each cycle that i is valid, the slot is free and another index wins.
//    - starve[i] clears on grant to i and whenever i is not valid.
//    - If any starve[i] >= STARVE_LIMIT, the lowest such i wins instead.
//  The slot not being free does not count as lost arbitration; starve counters hold.
//  Simultaneous: a requester whose packet is accepted may present a new packet the next cycle.
//    Its req_ready is never asserted for two consecutive cycles on a single packet.
//    Requesters deassert .valid or change the packet only after the req_ready pulse.
//  Reset mid-operation drops any buffered request; requesters must reissue.
//  Assertions: req_ready is one-hot or zero; l2req_packet is stable while valid && !l2req_ready.
// STRUCTURE
//  From the shared defines package:
//    - l2req_packet_t
//    - unit ID constants UNIT_ICACHE, UNIT_DCACHE, UNIT_STBUF
//  New sub-module rr_arbiter (NUM_REQ, request vector + enable -> one-hot grant, rotating pointer), reusable by the L2 side.
//  The starvation logic, output register and muxing stay in this module.
// TESTING
//  1. Reset, then req0 only, l2req_ready = 1 -> req_ready[0] at cycle 1; l2req_packet.valid at cycle 2 with req0 contents; grant_id = 0.
//  2. RR, all 3 valid continuously, l2req_ready = 1 -> grant order 0,1,2,0,1,2; one accept per cycle; no bubbles.
//  3. l2req_ready = 0 for 5 cycles with the output full ->
//     - l2req_packet stable;
//     - no req_ready pulses;
//     - pc_event_l2req_stall = 1 for 5 cycles;
//     - the next grant happens on the cycle ready returns.
//  4. Fixed, STARVE_LIMIT = 3, req0 always valid, req2 valid -> req2 granted on its 4th arbitration cycle; then req0 resumes.
//  5. RR, ptr = 2, only req0 and req1 valid -> req0 granted first (wrap-around); ptr becomes 1.
//  6. Assert reset while l2req_packet.valid = 1 with a stalled L2 -> valid = 0 and ptr = 0 immediately (async); no req_ready pulse until reset deasserts.

Source files
------------

// File: rtl/l2req_arbiter_rr_pkg.sv
// Shared L2 request definitions for the L1-to-L2 request path.
//   l2req_packet_t : one request beat towards the core L2 port (.valid = pending)
//   UNIT_*         : requester index assignment on the arbiter
package l2req_arbiter_rr_pkg;

    localparam int unsigned UNIT_ICACHE = 0;
    localparam int unsigned UNIT_DCACHE = 1;
    localparam int unsigned UNIT_STBUF  = 2;

    // Starvation counters are 8 bits wide and saturate here.
    localparam int unsigned STARVE_MAX = 255;

    typedef enum logic [1:0] {
        L2_CMD_READ,
        L2_CMD_WRITE,
        L2_CMD_PREFETCH,
        L2_CMD_FLUSH
    } l2req_cmd_e;

    typedef struct packed {
        logic        valid;
        l2req_cmd_e  cmd;
        logic [31:0] addr;
        logic [7:0]  tag;
    } l2req_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, reset  : clock, asynchronous active-high reset (pointer -> 0)
//   req         : request vector
//   enable      : arbitration allowed this cycle; pointer only moves on a grant
//   grant       : one-hot grant (zero when disabled or no request)
//   grant_idx   : index of the granted requester
//   grant_valid : a grant was made
module rr_arbiter
    import l2req_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Search starts at the pointer and wraps past NUM_REQ-1 back to 0.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        if (enable) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                sum = {1'b0, ptr_q} + (IDX_W + 1)'(off);
                if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W + 1)'(NUM_REQ);
                end
                idx = sum[IDX_W-1:0];
                if (!grant_valid && req[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/l2req_arbiter_rr.sv
// Merges the per-core L1 request sources onto the single core L2 request port.
//   clk, reset           : clock, asynchronous active-high reset
//   req_packet[i]        : request from requester i, held until req_ready[i]
//   req_ready[i]         : one-cycle pulse, packet i is latched at the next edge
//   l2req_ready          : L2 takes l2req_packet this cycle when it is valid
//   l2req_packet         : registered request towards L2
//   grant_id             : requester that owns l2req_packet
//   pc_event_l2req_stall : output is valid but L2 is not accepting
module l2req_arbiter_rr
    import l2req_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned FIXED_PRIO   = 0,
    parameter int unsigned STARVE_LIMIT = 15,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  l2req_packet_t [NUM_REQ-1:0]  req_packet,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         l2req_ready,
    output l2req_packet_t                l2req_packet,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         pc_event_l2req_stall
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be 2..8");
    end
    if (FIXED_PRIO > 1) begin : g_bad_fixed_prio
        $error("FIXED_PRIO must be 0 or 1");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > STARVE_MAX) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be 1..255");
    end

    logic               slot_free;
    logic               arb_en;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = req_packet[i].valid;
        end
    end

    // Drain and refill in the same cycle; nothing is granted while reset is held.
    assign slot_free = !l2req_packet.valid || l2req_ready;
    assign arb_en    = slot_free && !reset;

    if (FIXED_PRIO == 0) begin : g_rr
        rr_arbiter #(
            .NUM_REQ (NUM_REQ)
        ) u_rr_arbiter (
            .clk         (clk),
            .reset       (reset),
            .req         (req_valid),
            .enable      (arb_en),
            .grant       (gnt),
            .grant_idx   (gnt_idx),
            .grant_valid (gnt_valid)
        );
    end else begin : g_fixed
        logic [NUM_REQ-1:0][7:0] starve_q;
        logic [NUM_REQ-1:0]      starving;

        always_comb begin
            starving = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                starving[i] = req_valid[i] && (starve_q[i] >= 8'(STARVE_LIMIT));
            end
        end

        // Descending scans so the lowest matching index is the one left standing;
        // any starving requester overrides plain priority.
        always_comb begin
            gnt_idx   = '0;
            gnt_valid = 1'b0;
            if (arb_en) begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_valid[i]) begin
                        gnt_idx   = IDX_W'(i);
                        gnt_valid = 1'b1;
                    end
                end
                if (|starving) begin
                    for (int i = NUM_REQ - 1; i >= 0; i--) begin
                        if (starving[i]) begin
                            gnt_idx = IDX_W'(i);
                        end
                    end
                end
            end
            gnt = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
        end

        // A busy output slot is not a lost arbitration, so counters hold then.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                starve_q <= '0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!req_valid[i]) begin
                        starve_q[i] <= '0;
                    end else if (slot_free) begin
                        if (gnt[i]) begin
                            starve_q[i] <= '0;
                        end else if (starve_q[i] != 8'(STARVE_MAX)) begin
                            starve_q[i] <= starve_q[i] + 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign req_ready            = gnt;
    assign pc_event_l2req_stall = l2req_packet.valid && !l2req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2req_packet <= '0;
            grant_id     <= '0;
        end else if (gnt_valid) begin
            l2req_packet <= req_packet[gnt_idx];
            grant_id     <= gnt_idx;
        end else if (l2req_ready) begin
            l2req_packet.valid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (l2req_packet.valid && !l2req_ready) |=> $stable(l2req_packet));

endmodule

// File: tb/tb_l2req_arbiter_rr.sv
// Bench for l2req_arbiter_rr: instance 0 is round-robin, instance 1 is fixed priority
// with STARVE_LIMIT = 3. Both are checked every cycle against a behavioural model.
module tb_l2req_arbiter_rr;
    import l2req_arbiter_rr_pkg::*;

    localparam int N   = 3;
    localparam int LIM = 3;

    logic                  clk;
    logic                  reset;
    l2req_packet_t [N-1:0] req_pk [2];
    logic [N-1:0]          rdy    [2];
    logic                  l2rdy  [2];
    l2req_packet_t         outp   [2];
    logic [1:0]            gid    [2];
    logic                  stall  [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        l2req_arbiter_rr #(
            .NUM_REQ      (N),
            .FIXED_PRIO   (d),
            .STARVE_LIMIT (LIM)
        ) u_dut (
            .clk                  (clk),
            .reset                (reset),
            .req_packet           (req_pk[d]),
            .req_ready            (rdy[d]),
            .l2req_ready          (l2rdy[d]),
            .l2req_packet         (outp[d]),
            .grant_id             (gid[d]),
            .pc_event_l2req_stall (stall[d])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state and per-cycle bookkeeping
    l2req_packet_t m_pkt   [2];
    int            m_id    [2];
    int            m_ptr;
    int            m_starve [N];
    bit            want    [2][N];
    int            eg      [2];
    bit            efree   [2];
    int            act_g   [2];
    logic          a_stall [2];
    l2req_packet_t g_pkt   [2];
    int            n_total = 0;
    int            n_bad   = 0;
    int            seq     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic l2req_packet_t new_pkt();
        l2req_packet_t p;
        p.valid = 1'b1;
        p.cmd   = l2req_cmd_e'($urandom_range(3));
        p.addr  = $urandom;
        p.tag   = 8'(seq);
        seq++;
        return p;
    endfunction

    function automatic logic [N-1:0] onehot_of(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Which requester should win this cycle, -1 for none.
    function automatic int model_grant(input int d);
        if (m_pkt[d].valid && !l2rdy[d]) return -1;
        if (d == 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req_pk[0][i].valid) return i;
            end
        end else begin
            for (int i = 0; i < N; i++)
                if (req_pk[1][i].valid && m_starve[i] >= LIM) return i;
            for (int i = 0; i < N; i++)
                if (req_pk[1][i].valid) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input int d);
        if (eg[d] >= 0) begin
            m_pkt[d] = g_pkt[d];
            m_id[d]  = eg[d];
            if (d == 0) m_ptr = (eg[d] + 1) % N;
        end else if (l2rdy[d]) begin
            m_pkt[d].valid = 1'b0;
        end
        if (d == 1) begin
            for (int i = 0; i < N; i++) begin
                if (!req_pk[1][i].valid) m_starve[i] = 0;
                else if (efree[1]) begin
                    if (eg[1] == i) m_starve[i] = 0;
                    else if (m_starve[i] < 255) m_starve[i] = m_starve[i] + 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pkt[d] = '0;
            m_id[d]  = 0;
        end
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_starve[i] = 0;
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic tick();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                if (want[d][i] && !req_pk[d][i].valid) req_pk[d][i] = new_pkt();
        #1;
        for (int d = 0; d < 2; d++) begin
            eg[d]      = model_grant(d);
            efree[d]   = !m_pkt[d].valid || l2rdy[d];
            act_g[d]   = first_set(rdy[d]);
            a_stall[d] = stall[d];
            if (eg[d] >= 0) g_pkt[d] = req_pk[d][eg[d]];
            check($sformatf("d%0d_req_ready", d), 64'(rdy[d]), 64'(onehot_of(eg[d])));
            check($sformatf("d%0d_l2req_packet", d), outp[d], m_pkt[d]);
            check($sformatf("d%0d_grant_id", d), 64'(gid[d]), 64'(m_id[d]));
            check($sformatf("d%0d_stall", d), 64'(stall[d]),
                  64'(m_pkt[d].valid && !l2rdy[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_update(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                if (eg[d] == i) req_pk[d][i] = want[d][i] ? new_pkt() : '0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_valid", d), 64'(outp[d].valid), 64'd0);
            check($sformatf("d%0d_rst_pkt", d), outp[d], 64'd0);
            check($sformatf("d%0d_rst_gid", d), 64'(gid[d]), 64'd0);
            check($sformatf("d%0d_rst_ready", d), 64'(rdy[d]), 64'd0);
        end
        repeat (cycles) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                check($sformatf("d%0d_rst_hold_ready", d), 64'(rdy[d]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic bit any_pending(input int d);
        for (int i = 0; i < N; i++) if (req_pk[d][i].valid) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int d);
        int budget;
        budget = 40;
        for (int i = 0; i < N; i++) want[d][i] = 1'b0;
        l2rdy[d] = 1'b1;
        while (budget > 0 && any_pending(d)) begin
            tick();
            budget--;
        end
        check($sformatf("d%0d_drain_timeout", d), 64'(any_pending(d)), 64'd0);
    endtask

    initial begin
        l2req_packet_t held;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_pk[d] = '0;
            l2rdy[d]  = 1'b0;
            for (int i = 0; i < N; i++) want[d][i] = 1'b0;
        end
        model_reset();
        do_reset(2);

        // 1: single request, latency
        want[0][UNIT_ICACHE] = 1'b1;
        l2rdy[0] = 1'b1;
        tick();
        check("t1_ready0", 64'(act_g[0]), 64'd0);
        #1;
        check("t1_out_valid", 64'(outp[0].valid), 64'd1);
        check("t1_out_pkt", outp[0], g_pkt[0]);
        check("t1_gid", 64'(gid[0]), 64'd0);

        // 2: all three continuously, round-robin order, no bubbles
        do_reset(1);
        for (int i = 0; i < N; i++) want[0][i] = 1'b1;
        l2rdy[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_order", 64'(act_g[0]), 64'(k % N));
            #1;
            check("t2_no_bubble", 64'(outp[0].valid), 64'd1);
        end

        // 3: stalled L2 for five cycles
        l2rdy[0] = 1'b0;
        held = outp[0];
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_no_grant", 64'(act_g[0]), 64'hFFFF_FFFF_FFFF_FFFF);
            check("t3_stall", 64'(a_stall[0]), 64'd1);
            check("t3_stable", outp[0], held);
        end
        l2rdy[0] = 1'b1;
        tick();
        check("t3_resume", 64'(act_g[0]), 64'd0);

        // 4: fixed priority, req2 starves for three cycles then wins
        for (int i = 0; i < N; i++) want[0][i] = 1'b0;
        want[1][0] = 1'b1;
        want[1][2] = 1'b1;
        l2rdy[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_order", 64'(act_g[1]), 64'((k == 3) ? 2 : 0));
        end
        drain(1);

        // 5: pointer at 2, only req0/req1 -> wrap to 0, then 1
        drain(0);
        want[0][1] = 1'b1;
        tick();
        check("t5_setup", 64'(act_g[0]), 64'd1);
        want[0][0] = 1'b1;
        tick();
        check("t5_wrap", 64'(act_g[0]), 64'd0);
        tick();
        check("t5_next", 64'(act_g[0]), 64'd1);

        // 6: async reset with a stalled, full output
        for (int i = 0; i < N; i++) want[0][i] = 1'b1;
        tick();
        tick();
        l2rdy[0] = 1'b0;
        tick();
        tick();
        check("t6_full", 64'(outp[0].valid), 64'd1);
        do_reset(2);
        l2rdy[0] = 1'b1;
        tick();
        check("t6_ptr_reset", 64'(act_g[0]), 64'd0);

        // Random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) want[d][i] = ($urandom_range(99) < 60);
                l2rdy[d] = ($urandom_range(99) < 70);
            end
            if (c == 300) do_reset(1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
